// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver FSM state encoding
package uart_pkg;

  // 100 MHz system clock at 115200 baud; shared with the transmitter
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte and status bundle driven by uart_rx
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_done,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_done,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer with configurable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver sampling each bit at its centre
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  uart_rx_if.master  rx_if
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic rxd_s;

  rx_state_e        state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       idx_q,       idx_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic [7:0]       rx_data_q,   rx_data_d;
  logic             rx_done_q,   rx_done_d;
  logic             frame_err_q, frame_err_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rxd),
    .q_o     (rxd_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) begin
          state_d = ST_START;
        end
      end

      // A start bit that has gone high again by its centre is treated as noise
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end

      // Leaving at the stop-bit centre leaves half a bit to catch the next start edge
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            rx_data_d = shreg_q;
            rx_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end

      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_done   = rx_done_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks for uart_rx
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rxd = 1'b1;
  int   cyc = 0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got_data[$];
  int         done_cyc[$];
  int         ferr_cnt = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_busy = 1'b0;
  logic       busy_at_done = 1'b1;
  logic       busy_before_done = 1'b0;

  uart_rx_if u_if();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .rx_if (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: records every delivered byte and checks pulse shape on the fly
  always @(negedge clk) begin
    if (u_if.rx_done === 1'b1) begin
      got_data.push_back(u_if.rx_data);
      done_cyc.push_back(cyc);
      busy_at_done     = u_if.rx_busy;
      busy_before_done = prev_busy;
      check("done_single_exclusive", {29'd0, prev_done, prev_ferr, u_if.frame_err}, 32'd0);
    end
    if (u_if.frame_err === 1'b1) begin
      ferr_cnt++;
      check("ferr_single_exclusive", {30'd0, prev_ferr, prev_done}, 32'd0);
    end
    prev_done = u_if.rx_done;
    prev_ferr = u_if.frame_err;
    prev_busy = u_if.rx_busy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
  endtask

  initial begin
    int         base;
    int         fall;
    int         f0;
    logic [7:0] last_good;
    logic [7:0] b;
    logic       good;
    logic [7:0] exp_q[$];
    int         exp_ferr;
    logic [7:0] seq4[4];

    seq4[0] = 8'h31; seq4[1] = 8'h34; seq4[2] = 8'h31; seq4[3] = 8'h36;

    #2 reset = 1'b1;
    #1;
    check("reset_rx_data", u_if.rx_data, 8'h00);
    check("reset_rx_done", u_if.rx_done, 1'b0);
    check("reset_frame_err", u_if.frame_err, 1'b0);
    check("reset_rx_busy", u_if.rx_busy, 1'b0);
    idle(3);
    reset = 1'b0;
    idle(10);

    // Single well-formed frame
    base = got_data.size();
    fall = cyc;
    send_frame(8'h31, 1'b1);
    idle(20);
    check("t1_done_count", got_data.size() - base, 1);
    check("t1_data", got_data[base], 8'h31);
    check("t1_no_ferr", ferr_cnt, 0);
    check("t1_busy_low_at_done", busy_at_done, 1'b0);
    check("t1_busy_high_before_done", busy_before_done, 1'b1);
    check("t1_latency_window",
          ((done_cyc[base] - fall) >= (2 + CPB / 2 + 9 * CPB - 2)) &&
          ((done_cyc[base] - fall) <= (2 + CPB / 2 + 9 * CPB + 2)), 1'b1);

    // Back-to-back frames with one stop bit
    base = got_data.size();
    for (int k = 0; k < 4; k++) send_frame(seq4[k], 1'b1);
    idle(20);
    check("t2_done_count", got_data.size() - base, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_data%0d", k), got_data[base + k], seq4[k]);
    for (int k = 0; k < 3; k++)
      check($sformatf("t2_spacing%0d", k), done_cyc[base + k + 1] - done_cyc[base + k], FRAME);
    last_good = 8'h36;

    // Short glitch below half a bit
    base = got_data.size();
    f0 = ferr_cnt;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(10);
    check("t3_busy_clear", u_if.rx_busy, 1'b0);
    idle(10);
    check("t3_no_done", got_data.size() - base, 0);
    check("t3_no_ferr", ferr_cnt - f0, 0);
    check("t3_data_held", u_if.rx_data, last_good);

    // Framing error followed by a long low line
    base = got_data.size();
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    rxd = 1'b0;
    idle(30);
    check("t4_busy_while_low", u_if.rx_busy, 1'b1);
    idle(10);
    check("t4_ferr_count", ferr_cnt - f0, 1);
    check("t4_no_done", got_data.size() - base, 0);
    check("t4_data_held", u_if.rx_data, last_good);
    rxd = 1'b1;
    idle(5);
    check("t4_busy_clear", u_if.rx_busy, 1'b0);
    idle(10);

    // Reset in the middle of data bit 3
    base = got_data.size();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b_of(8'h5A, i));
    rxd = b_of(8'h5A, 3);
    idle(CPB / 2);
    reset = 1'b1;
    rxd = 1'b1;
    #1;
    check("t5_reset_data", u_if.rx_data, 8'h00);
    check("t5_reset_busy", u_if.rx_busy, 1'b0);
    check("t5_reset_done", u_if.rx_done, 1'b0);
    idle(3);
    reset = 1'b0;
    idle(20);
    check("t5_no_aborted_done", got_data.size() - base, 0);
    send_frame(8'h5A, 1'b1);
    idle(20);
    check("t5_done_count", got_data.size() - base, 1);
    check("t5_data", got_data[base], 8'h5A);

    // All ones then all zeros
    base = got_data.size();
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(20);
    check("t6_done_count", got_data.size() - base, 2);
    check("t6_data_ff", got_data[base], 8'hFF);
    check("t6_data_00", got_data[base + 1], 8'h00);
    last_good = 8'h00;

    // Randomized frames against a byte-queue model
    base = got_data.size();
    f0 = ferr_cnt;
    exp_ferr = 0;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good);
      if (good) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_ferr++;
        rxd = 1'b0;
        idle($urandom_range(0, 20));
        rxd = 1'b1;
        idle(4);
      end
      idle($urandom_range(0, 12));
    end
    idle(20);
    check("rand_done_count", got_data.size() - base, exp_q.size());
    check("rand_ferr_count", ferr_cnt - f0, exp_ferr);
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("rand_data%0d", k), got_data[base + k], exp_q[k]);
    check("rand_final_data", u_if.rx_data, last_good);
    check("rand_idle_busy", u_if.rx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  function automatic logic b_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
